agc_cdu_interface: RTL and testbench



---
 rtl/agc_cdu_interface.sv | 174 +++++++++++++++++
 tb/tb_agc_cdu_interface.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/agc_cdu_interface.sv
// AGC-side CDU interface: CLOCKH divider, moding discretes and +/- angle pulse counter.
// Optional pulse-rate checker enabled by defining CDU_PULSE_RATE_CHECK_EN.
`timescale 1ns/1ps

module agc_cdu_interface #(
    parameter int unsigned CLKH_LOW    = 38,
    parameter int unsigned CLKH_HIGH   = 212,
    parameter int unsigned CNT_W       = 15,
    parameter int unsigned SYNC_STAGES = 2
`ifdef CDU_PULSE_RATE_CHECK_EN
    ,
    parameter int unsigned MIN_GAP     = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             CLOCKH,
    input  logic             cdu_plus,
    input  logic             cdu_minus,
    input  logic             ca_req,
    input  logic             zero_req,
    input  logic             eec_req,
    output logic             AGCCA,
    output logic             AGCZ,
    output logic             AGCEEC,
    output logic [CNT_W-1:0] cdu_count,
    output logic             cnt_wrap,
    output logic             rate_err
);

    localparam int unsigned DIV_MAX = (CLKH_LOW > CLKH_HIGH) ? CLKH_LOW : CLKH_HIGH;
    localparam int unsigned DIV_W   = $clog2(DIV_MAX + 1);

    typedef enum logic [0:0] {StLow, StHigh} clkh_state_e;

    clkh_state_e      r_state, w_state_next;
    logic [DIV_W-1:0] r_div, w_div_next;
    logic             r_clkh;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StLow;
            r_div   <= '0;
            r_clkh  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_div   <= w_div_next;
            r_clkh  <= (w_state_next == StHigh);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div + 1'b1;
        unique case (r_state)
            StLow: begin
                if (r_div == DIV_W'(CLKH_LOW - 1)) begin
                    w_state_next = StHigh;
                    w_div_next   = '0;
                end
            end
            StHigh: begin
                if (r_div == DIV_W'(CLKH_HIGH - 1)) begin
                    w_state_next = StLow;
                    w_div_next   = '0;
                end
            end
            default: begin
                w_state_next = StLow;
                w_div_next   = '0;
            end
        endcase
    end

    logic r_agcca, r_agcz, r_agceec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_agcca  <= 1'b0;
            r_agcz   <= 1'b0;
            r_agceec <= 1'b0;
        end else begin
            r_agcca  <= ca_req;
            r_agcz   <= zero_req;
            r_agceec <= eec_req;
        end
    end

    // Pulse lines are asynchronous to clk; synchronize before edge detection.
    logic [SYNC_STAGES-1:0] r_plus_sync, r_minus_sync;
    logic                   r_plus_prev, r_minus_prev;
    logic                   w_edge_p, w_edge_m;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_plus_sync  <= '0;
            r_minus_sync <= '0;
            r_plus_prev  <= 1'b0;
            r_minus_prev <= 1'b0;
        end else begin
            r_plus_sync  <= {r_plus_sync[SYNC_STAGES-2:0], cdu_plus};
            r_minus_sync <= {r_minus_sync[SYNC_STAGES-2:0], cdu_minus};
            r_plus_prev  <= r_plus_sync[SYNC_STAGES-1];
            r_minus_prev <= r_minus_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge_p = r_plus_sync[SYNC_STAGES-1] & ~r_plus_prev;
    assign w_edge_m = r_minus_sync[SYNC_STAGES-1] & ~r_minus_prev;

    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_wrap, w_wrap_next;

    always_comb begin
        w_cnt_next  = r_cnt;
        w_wrap_next = 1'b0;
        if (r_agcz) begin
            w_cnt_next = '0;
        end else if (w_edge_p && !w_edge_m) begin
            w_cnt_next  = r_cnt + 1'b1;
            w_wrap_next = &r_cnt;
        end else if (w_edge_m && !w_edge_p) begin
            w_cnt_next  = r_cnt - 1'b1;
            w_wrap_next = ~|r_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_wrap <= w_wrap_next;
        end
    end

`ifdef CDU_PULSE_RATE_CHECK_EN
    localparam int unsigned GAP_W = $clog2(MIN_GAP + 1);

    logic [GAP_W-1:0] r_gap;
    logic             r_rate_err;
    logic             w_any_edge;

    assign w_any_edge = w_edge_p | w_edge_m;

    // Gap starts saturated so the first edge after reset is always legal.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gap      <= GAP_W'(MIN_GAP);
            r_rate_err <= 1'b0;
        end else if (w_any_edge) begin
            r_gap <= GAP_W'(1);
            if (r_gap < GAP_W'(MIN_GAP)) begin
                r_rate_err <= 1'b1;
            end
        end else if (r_gap < GAP_W'(MIN_GAP)) begin
            r_gap <= r_gap + 1'b1;
        end
    end

    assign rate_err = r_rate_err;
`else
    assign rate_err = 1'b0;
`endif

    assign CLOCKH    = r_clkh;
    assign AGCCA     = r_agcca;
    assign AGCZ      = r_agcz;
    assign AGCEEC    = r_agceec;
    assign cdu_count = r_cnt;
    assign cnt_wrap  = r_wrap;

endmodule

// File: tb/tb_agc_cdu_interface.sv
// Directed self-checking bench for agc_cdu_interface (default parameters).
`timescale 1ns/1ps

module tb_agc_cdu_interface;

    logic        clk;
    logic        rst_n;
    logic        CLOCKH;
    logic        cdu_plus, cdu_minus;
    logic        ca_req, zero_req, eec_req;
    logic        AGCCA, AGCZ, AGCEEC;
    logic [14:0] cdu_count;
    logic        cnt_wrap;
    logic        rate_err;

    int n_tests = 0;
    int n_fail  = 0;

    agc_cdu_interface u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .CLOCKH    (CLOCKH),
        .cdu_plus  (cdu_plus),
        .cdu_minus (cdu_minus),
        .ca_req    (ca_req),
        .zero_req  (zero_req),
        .eec_req   (eec_req),
        .AGCCA     (AGCCA),
        .AGCZ      (AGCZ),
        .AGCEEC    (AGCEEC),
        .cdu_count (cdu_count),
        .cnt_wrap  (cnt_wrap),
        .rate_err  (rate_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cdu_plus  = 1'b0;
        cdu_minus = 1'b0;
        ca_req    = 1'b0;
        zero_req  = 1'b0;
        eec_req   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse(input bit p, input bit m, input int width, input int gap);
        cdu_plus  = p;
        cdu_minus = m;
        repeat (width) tick();
        cdu_plus  = 1'b0;
        cdu_minus = 1'b0;
        repeat (gap) tick();
    endtask

    initial begin
        do_reset();
        check_eq("rst_clockh", CLOCKH, 0);
        check_eq("rst_cnt", cdu_count, 0);
        check_eq("rst_wrap", cnt_wrap, 0);
        check_eq("rst_moding", {AGCCA, AGCZ, AGCEEC}, 0);
        check_eq("rst_rate", rate_err, 0);

        // CLOCKH: low for cycles 0..37, high 38..249, period 250
        for (int n = 0; n < 500; n++) begin
            check_eq("clockh", CLOCKH, ((n % 250) >= 38) ? 1 : 0);
            tick();
        end
        check_eq("idle_cnt", cdu_count, 0);
        check_eq("idle_moding", {AGCCA, AGCZ, AGCEEC}, 0);

        // Reset during HIGH truncates the period
        repeat (100) tick();
        check_eq("mid_high", CLOCKH, 1);
        do_reset();
        check_eq("mid_rst", CLOCKH, 0);
        repeat (37) tick();
        check_eq("mid_low37", CLOCKH, 0);
        tick();
        check_eq("mid_high38", CLOCKH, 1);

        // Latency: count changes on the 3rd edge counting the sampling edge
        do_reset();
        cdu_plus = 1'b1;
        tick();
        tick();
        check_eq("lat_pre", cdu_count, 0);
        tick();
        check_eq("lat_post", cdu_count, 1);
        tick();
        cdu_plus = 1'b0;
        repeat (20) tick();
        pulse(1, 0, 4, 20);
        pulse(1, 0, 4, 20);
        check_eq("three_plus", cdu_count, 3);
        pulse(1, 0, 50, 10);
        check_eq("long_plus", cdu_count, 4);

        // Moding discretes: 1-cycle registered copies
        ca_req = 1'b1;
        check_eq("ca_pre", AGCCA, 0);
        tick();
        check_eq("ca_post", AGCCA, 1);
        eec_req = 1'b1;
        tick();
        check_eq("eec_post", AGCEEC, 1);
        check_eq("ca_eec_cnt", cdu_count, 4);
        ca_req  = 1'b0;
        eec_req = 1'b0;
        tick();
        check_eq("moding_clr", {AGCCA, AGCEEC}, 0);

        // Minus from 0 wraps to 0x7FFF, then plus wraps back to 0
        do_reset();
        cdu_minus = 1'b1;
        tick();
        tick();
        check_eq("mwrap_pre", {cnt_wrap, 1'b0, cdu_count}, 0);
        tick();
        check_eq("mwrap_cnt", cdu_count, 32'h7FFF);
        check_eq("mwrap_pulse", cnt_wrap, 1);
        tick();
        check_eq("mwrap_end", cnt_wrap, 0);
        check_eq("mwrap_hold", cdu_count, 32'h7FFF);
        cdu_minus = 1'b0;
        repeat (5) tick();
        cdu_plus = 1'b1;
        tick();
        tick();
        check_eq("pwrap_pre", cnt_wrap, 0);
        tick();
        check_eq("pwrap_cnt", cdu_count, 0);
        check_eq("pwrap_pulse", cnt_wrap, 1);
        tick();
        check_eq("pwrap_end", cnt_wrap, 0);
        cdu_plus = 1'b0;
        repeat (5) tick();

        // Simultaneous plus and minus cancel
        do_reset();
        repeat (5) pulse(1, 0, 2, 3);
        check_eq("five", cdu_count, 5);
        cdu_plus  = 1'b1;
        cdu_minus = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("both_wrap", cnt_wrap, 0);
        end
        check_eq("both_cnt", cdu_count, 5);
        cdu_plus  = 1'b0;
        cdu_minus = 1'b0;
        repeat (4) tick();
        check_eq("both_cnt_end", cdu_count, 5);

        // Zero request discards pulses while AGCZ is high
        do_reset();
        repeat (100) pulse(1, 0, 2, 2);
        check_eq("hundred", cdu_count, 100);
        zero_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cdu_plus = (i < 8 && (i % 2) == 0);
            tick();
            check_eq("zero_agcz", AGCZ, 1);
            check_eq("zero_cnt", cdu_count, (i == 0) ? 100 : 0);
        end
        cdu_plus = 1'b0;
        zero_req = 1'b0;
        tick();
        check_eq("zero_fall", AGCZ, 0);
        check_eq("zero_fall_cnt", cdu_count, 0);
        repeat (3) tick();
        check_eq("zero_after", cdu_count, 0);
        pulse(1, 0, 4, 5);
        check_eq("zero_then_one", cdu_count, 1);

`ifdef CDU_PULSE_RATE_CHECK_EN
        // Edges 5 cycles apart violate the minimum gap
        do_reset();
        pulse(1, 0, 1, 4);
        pulse(1, 0, 1, 8);
        check_eq("rate_set", rate_err, 1);
        check_eq("rate_cnt", cdu_count, 2);
        repeat (20) tick();
        check_eq("rate_sticky", rate_err, 1);
        do_reset();
        check_eq("rate_rst", rate_err, 0);
        repeat (4) pulse(1, 0, 1, 9);
        repeat (5) tick();
        check_eq("rate_ok", rate_err, 0);
        check_eq("rate_ok_cnt", cdu_count, 4);
`else
        do_reset();
        pulse(1, 0, 1, 4);
        pulse(1, 0, 1, 8);
        check_eq("rate_tied", rate_err, 0);
        check_eq("rate_cnt", cdu_count, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
